// File: rtl/apple1_pia.sv
// Apple-1 style PIA: keyboard FIFO and display handshake behind the $D010-$D013 bus window.
// The read data mux is combinational; all state changes happen on the rising clk edge.
module apple1_pia #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [6:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    output logic [6:0] dsp_data,
    output logic       dsp_valid,
    input  logic       dsp_ready
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        REG_KBD   = 2'd0,
        REG_KBDCR = 2'd1,
        REG_DSP   = 2'd2,
        REG_DSPCR = 2'd3
    } reg_sel_e;

    logic [6:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   count;
    logic [6:0]         kbdcr;
    logic [6:0]         dspcr;
    logic               busy;

    logic empty;
    logic full;
    logic bus_rd;
    logic bus_wr;
    logic push;
    logic pop;
    logic dsp_done;
    logic dsp_accept;

    assign empty      = (count == '0);
    assign full       = (count == (FIFO_AW + 1)'(DEPTH));
    assign kbd_ready  = ~full;
    assign dsp_valid  = busy;

    assign bus_rd     = enable & cs & ~we;
    assign bus_wr     = enable & cs & we;
    assign push       = kbd_valid & kbd_ready;
    assign pop        = bus_rd & (addr == REG_KBD) & ~empty;

    // A completing transfer frees the display register on the same edge a new write lands.
    assign dsp_done   = busy & dsp_ready;
    assign dsp_accept = bus_wr & (addr == REG_DSP) & (~busy | dsp_ready);

    // NOTE: the FIFO storage has no reset; the empty flag masks whatever stale data it holds.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= kbd_data;
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            kbdcr    <= '0;
            dspcr    <= '0;
            busy     <= 1'b0;
            dsp_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (bus_wr && addr == REG_KBDCR) kbdcr <= din[6:0];
            if (bus_wr && addr == REG_DSPCR) dspcr <= din[6:0];

            if (dsp_accept) begin
                dsp_data <= din[6:0];
                busy     <= 1'b1;
            end else if (dsp_done) begin
                busy     <= 1'b0;
            end
        end
    end

    // NOTE: every path assigns dout first, so this block cannot infer a latch.
    always_comb begin
        dout = 8'h00;
        case (addr)
            REG_KBD:   dout = empty ? 8'h00 : {1'b1, mem[rd_ptr]};
            REG_KBDCR: dout = {~empty, kbdcr};
            REG_DSP:   dout = {busy, dsp_data};
            REG_DSPCR: dout = {1'b0, dspcr};
            default:   dout = 8'h00;
        endcase
    end

endmodule
